// File: rtl/bram16_arbiter.sv
// Two-requester arbiter in front of one bram16 port (1-cycle synchronous read).
// The bram write-data output is called dout because `do` is a reserved word.
module bram16_arbiter #(
    parameter bit RR = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_a,
    input  logic [15:0] m0_do,
    output logic [15:0] m0_di,
    output logic        m0_ack,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_a,
    input  logic [15:0] m1_do,
    output logic [15:0] m1_di,
    output logic        m1_ack,

    output logic        we,
    output logic [15:0] a,
    output logic [15:0] dout,
    input  logic [15:0] di,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    state_t      state, state_nx;
    logic        grant, grant_nx;          // 0 = m0, 1 = m1
    logic        last_grant, last_grant_nx;
    logic        wr, wr_nx;                // access in flight is a write
    logic        we_nx;
    logic [15:0] a_nx, dout_nx;
    logic [15:0] m0_di_nx, m1_di_nx;
    logic        m0_ack_nx, m1_ack_nx;
    logic        busy_nx;
    logic        pick;

    // Winner if arbitration happened this cycle; under contention RR favours
    // whoever did not get the previous grant.
    always_comb begin
        if (m0_req && m1_req)
            pick = RR ? ~last_grant : 1'b0;
        else
            pick = m1_req;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_nx      = state;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        wr_nx         = wr;
        we_nx         = 1'b0;
        a_nx          = a;
        dout_nx       = dout;
        m0_di_nx      = m0_di;
        m1_di_nx      = m1_di;
        m0_ack_nx     = 1'b0;
        m1_ack_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_nx      = pick;
                    last_grant_nx = pick;
                    wr_nx         = pick ? m1_we : m0_we;
                    we_nx         = pick ? m1_we : m0_we;
                    a_nx          = pick ? m1_a  : m0_a;
                    dout_nx       = pick ? m1_do : m0_do;
                    state_nx      = ISSUE;
                end
            end
            ISSUE: begin
                // The bram samples a/we/dout on this edge; writes are done now.
                if (wr) begin
                    m0_ack_nx = ~grant;
                    m1_ack_nx = grant;
                    state_nx  = ACK;
                end else begin
                    state_nx  = WAIT;
                end
            end
            WAIT: begin
                if (grant)
                    m1_di_nx = di;
                else
                    m0_di_nx = di;
                m0_ack_nx = ~grant;
                m1_ack_nx = grant;
                state_nx  = ACK;
            end
            ACK: begin
                // Requests are not looked at here, so a held req is not granted twice.
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (sys_rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wr         <= 1'b0;
            we         <= 1'b0;
            a          <= '0;
            dout       <= '0;
            m0_di      <= '0;
            m1_di      <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_grant <= last_grant_nx;
            wr         <= wr_nx;
            we         <= we_nx;
            a          <= a_nx;
            dout       <= dout_nx;
            m0_di      <= m0_di_nx;
            m1_di      <= m1_di_nx;
            m0_ack     <= m0_ack_nx;
            m1_ack     <= m1_ack_nx;
            busy       <= busy_nx;
        end
    end

endmodule

// File: doc/bram16_arbiter.md
Name: bram16_arbiter

Overview:
- Two-requester arbiter sharing one bram16 instance (16-bit address, 16-bit data, single `we`, 1-cycle synchronous read).
- Requester 0 is typically the CPU data port; requester 1 a DMA/debug port.
- Sequences each access through a small FSM and returns read data with a one-cycle ack pulse.
- Selection policy is round-robin or fixed priority (m0 wins), chosen by parameter.

Parameters:
- RR, default 1: 1 = round-robin between m0 and m1; 0 = fixed priority, m0 always wins.

Ports:
- sys_clk  in  1  system clock; all logic on posedge
- sys_rst  in  1  synchronous, active-high reset
- m0_req  in  1  m0 access request, level
- m0_we  in  1  m0 write enable (1 write, 0 read)
- m0_a  in  16  m0 address
- m0_do  in  16  m0 write data
- m0_di  out  16  m0 read data, registered
- m0_ack  out  1  m0 completion pulse, one cycle
- m1_req, m1_we, m1_a, m1_do, m1_di, m1_ack  same as m0, for requester 1
- we  out  1  to bram16 we
- a  out  16  to bram16 a
- do  out  16  to bram16 do (write data)
- di  in  16  from bram16 di; valid the cycle after the address edge
- busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (sys_rst=1 at posedge) from any state:
  - FSM goes to IDLE; we, a, do = 0; m0_ack, m1_ack = 0; m0_di, m1_di = 0; busy = 0.
  - last_grant set to 1, so m0 wins the first contention under RR.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req is high at posedge: select a master, latch its we/a/do onto the bram outputs, record grant and last_grant, go to ISSUE.
  - No req: stay IDLE, we=0.
- Selection:
  - Only one req high: that master.
  - Both high, RR=1: the master that is not last_grant.
  - Both high, RR=0: m0.
- ISSUE: bram16 samples a/we/do at this edge. Clear we at the same edge.
  - Write: go to ACK and assert the granted mX_ack.
  - Read: go to WAIT.
- WAIT: capture di into the granted mX_di, assert the granted mX_ack, go to ACK.
- ACK: ack is high for exactly this one cycle. Deassert ack, go to IDLE.
  - Requests are ignored in ACK, so a req held high through ack is not double-granted; it is re-arbitrated in IDLE on the next edge.
- Timing (req first high in cycle 0, arbiter idle):
  - Write: bram write at edge 2; ack high in cycle 2; next grant possible at edge 4.
  - Read: ack and mX_di valid in cycle 3; next grant possible at edge 5.
  - Throughput: 1 write per 3 cycles, 1 read per 4 cycles.
- Requester rules:
  - we/a/do need only be stable at the granting edge; later changes do not affect the access in flight.
  - Requester keeps req high until it sees ack; dropping req before grant withdraws the request.
- mX_di holds its last read value until that master's next read completes; writes and the other master's reads never change it.
- Only the granted master's ack ever pulses; m0_ack and m1_ack are never high together.
- Reset mid-operation:
  - Access is aborted; no ack is issued.
  - A write reaching ISSUE before the reset edge has already committed in bram16; any later write has not.
- bram a/do retain the last granted values between accesses; only we is forced to 0 outside ISSUE.

Test Plan:
- Reset: sys_rst high 2 cycles -> we=0, a=0, do=0, m0_ack=m1_ack=0, m0_di=m1_di=0, busy=0.
- m0 writes 0x0100 <- 0x0100, then reads 0x0100 -> write ack in cycle 2, read ack in cycle 3 with m0_di=0x0100; we high for exactly one cycle.
- RR=1, m0 and m1 both hold read req of 0x0200 / 0x0300 (preloaded 0x0200 / 0x0300) -> grants alternate m0, m1, m0; data correct per master; acks never overlap.
- RR=0, both reqs held continuously -> m1 never acked while m0_req is high; m1 acked on the first IDLE after m0_req drops.
- Back-to-back: m0 holds req high across ack for writes to 0x0100..0x0400 -> exactly one bram write per ack; writes land 3 cycles apart; each address holds its data on readback.
- Reset asserted during WAIT of an m1 read -> no m1_ack; m1_di stays 0; FSM is IDLE and busy=0 the cycle after reset releases.
